// File: rtl/useq_pkg.sv
// Shared encodings for the microsequencer control block: opcodes, slice mux
// selects and control-state encoding.
package useq_pkg;

  localparam logic [3:0] OP_CONT = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_CJMP = 4'h2;
  localparam logic [3:0] OP_JSR  = 4'h3;
  localparam logic [3:0] OP_CJSR = 4'h4;
  localparam logic [3:0] OP_RTS  = 4'h5;
  localparam logic [3:0] OP_CRTS = 4'h6;
  localparam logic [3:0] OP_LDCT = 4'h7;
  localparam logic [3:0] OP_RPCT = 4'h8;
  localparam logic [3:0] OP_LDAR = 4'h9;
  localparam logic [3:0] OP_JAR  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_D   = 2'b11;

  localparam logic [2:0] STK_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/useq_loop_ctr.sv
// Loop counter for repeat-style microcode: load, saturating decrement, zero detect.
module useq_loop_ctr #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ld,
  input  logic          dec,
  input  logic [CW-1:0] din,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (ld)          cnt <= din;
    else if (dec && !zero) cnt <= cnt - CW'(1);
  end

endmodule

// File: rtl/useq_ctl.sv
// Microsequencer control: pipeline register, sequencing decode, reset/start FSM.
// Define USEQ_STACK_CHECK_EN to track stack depth and flag overflow/underflow.
module useq_ctl
  import useq_pkg::*;
#(
  parameter  int AW    = 4,
  parameter  int CW    = 8,
  parameter  int NCOND = 8,
  localparam int CSW   = (NCOND > 1) ? $clog2(NCOND) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       ui_op,
  input  logic [AW-1:0]    ui_branch,
  input  logic [CSW-1:0]   ui_csel,
  input  logic             ui_cpol,
  input  logic [NCOND-1:0] cond,
  input  logic             stall,
  output logic [1:0]       seq_s,
  output logic             seq_fe_n,
  output logic             seq_pup,
  output logic             seq_zero_n,
  output logic             seq_cin,
  output logic             seq_re_n,
  output logic [AW-1:0]    seq_d,
  output logic [AW-1:0]    seq_r,
  output logic [CW-1:0]    loop_cnt,
  output logic             illegal_op,
  output logic             stk_ovf,
  output logic             stk_unf
);

  state_t         state;
  logic [3:0]     p_op;
  logic [AW-1:0]  p_br;
  logic [CSW-1:0] p_csel;
  logic           p_cpol;
  logic           ct, ld, dec, lc_zero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RST;
      p_op       <= OP_CONT;
      p_br       <= '0;
      p_csel     <= '0;
      p_cpol     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (state)
        ST_RST: state <= ST_INIT;
        ST_INIT: begin
          state  <= ST_RUN;
          p_op   <= ui_op;
          p_br   <= ui_branch;
          p_csel <= ui_csel;
          p_cpol <= ui_cpol;
        end
        ST_RUN: if (!stall) begin
          p_op       <= ui_op;
          p_br       <= ui_branch;
          p_csel     <= ui_csel;
          p_cpol     <= ui_cpol;
          illegal_op <= (p_op >= 4'hC);
        end
        default: state <= ST_RST;
      endcase
    end
  end

  // Stalled RUN re-emits the current address: PC selected without increment.
  always_comb begin
    ct         = cond[p_csel] ^ p_cpol;
    seq_s      = SEL_PC;
    seq_fe_n   = 1'b1;
    seq_pup    = 1'b0;
    seq_zero_n = 1'b1;
    seq_cin    = 1'b1;
    seq_re_n   = 1'b1;
    ld         = 1'b0;
    dec        = 1'b0;
    case (state)
      ST_RST:  begin seq_zero_n = 1'b0; seq_cin = 1'b0; end
      ST_INIT: seq_zero_n = 1'b0;
      default:
        if (stall) seq_cin = 1'b0;
        else case (p_op)
          OP_JMP:  seq_s = SEL_D;
          OP_CJMP: if (ct) seq_s = SEL_D;
          OP_JSR, OP_CJSR:
            if (p_op == OP_JSR || ct) begin
              seq_s = SEL_D; seq_fe_n = 1'b0; seq_pup = 1'b1;
            end
          OP_RTS, OP_CRTS:
            if (p_op == OP_RTS || ct) begin
              seq_s = SEL_STK; seq_fe_n = 1'b0;
            end
          OP_LDCT: ld = 1'b1;
          OP_RPCT: if (!lc_zero) begin seq_s = SEL_D; dec = 1'b1; end
          OP_LDAR: seq_re_n = 1'b0;
          OP_JAR:  seq_s = SEL_AR;
          OP_JZ:   seq_zero_n = 1'b0;
          default: ;
        endcase
    endcase
  end

  assign seq_d = p_br;
  assign seq_r = p_br;

  useq_loop_ctr #(.CW(CW)) u_loop (
    .clock   (clock),
    .reset_n (reset_n),
    .ld      (ld),
    .dec     (dec),
    .din     (CW'(p_br)),
    .cnt     (loop_cnt),
    .zero    (lc_zero)
  );

`ifdef USEQ_STACK_CHECK_EN
  logic [2:0] depth;
  logic       push, pop;
  assign push = ~seq_fe_n &  seq_pup;
  assign pop  = ~seq_fe_n & ~seq_pup;

  // The slice still performs an out-of-range push; only the flag records it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (push) begin
      if (depth == STK_MAX) stk_ovf <= 1'b1;
      else                  depth   <= depth + 3'd1;
    end else if (pop) begin
      if (depth == '0) stk_unf <= 1'b1;
      else             depth   <= depth - 3'd1;
    end
  end
`else
  assign stk_ovf = 1'b0;
  assign stk_unf = 1'b0;
`endif

endmodule

// File: tb/tb_useq_ctl.sv
// Scoreboard bench for useq_ctl: directed scenarios plus random microcode
// checked each cycle against an instruction-level reference model.
module tb_useq_ctl;
  import useq_pkg::*;

  localparam int AW = 4, CW = 8, NCOND = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       ui_op = '0;
  logic [AW-1:0]    ui_branch = '0;
  logic [2:0]       ui_csel = '0;
  logic             ui_cpol = 1'b0;
  logic [NCOND-1:0] cond = '0;
  logic             stall = 1'b0;
  logic [1:0]       seq_s;
  logic             seq_fe_n, seq_pup, seq_zero_n, seq_cin, seq_re_n;
  logic [AW-1:0]    seq_d, seq_r;
  logic [CW-1:0]    loop_cnt;
  logic             illegal_op, stk_ovf, stk_unf;

  always #5 clock = ~clock;

  useq_ctl dut (
    .clock(clock), .reset_n(reset_n), .ui_op(ui_op), .ui_branch(ui_branch),
    .ui_csel(ui_csel), .ui_cpol(ui_cpol), .cond(cond), .stall(stall),
    .seq_s(seq_s), .seq_fe_n(seq_fe_n), .seq_pup(seq_pup), .seq_zero_n(seq_zero_n),
    .seq_cin(seq_cin), .seq_re_n(seq_re_n), .seq_d(seq_d), .seq_r(seq_r),
    .loop_cnt(loop_cnt), .illegal_op(illegal_op), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  typedef logic [25:0] obs_t;
  obs_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference model: phase 0 reset, 1 start-up, 2 running; word being executed.
  int            m_phase, m_cnt, m_depth;
  logic [3:0]    m_op;
  logic [AW-1:0] m_br;
  logic [2:0]    m_csel;
  logic          m_cpol, m_ill, m_ovf, m_unf;

  function automatic obs_t pack(logic [1:0] s, logic fe, logic pup, logic zn, logic cin,
                                logic re, logic [AW-1:0] d, logic [AW-1:0] r,
                                logic [CW-1:0] cnt, logic ill, logic ovf, logic unf);
    return {s, fe, pup, zn, cin, re, d, r, cnt, ill, ovf, unf};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_depth = 0; m_op = 4'h0; m_br = '0;
    m_csel = '0; m_cpol = 1'b0; m_ill = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // What the executing word does: 0 next, 1 go to D, 2 call D, 3 return, 4 go to AR.
  function automatic int action(input logic [NCOND-1:0] c);
    bit t = c[m_csel] ^ m_cpol;
    case (m_op)
      4'h1: return 1;
      4'h2: return t ? 1 : 0;
      4'h3: return 2;
      4'h4: return t ? 2 : 0;
      4'h5: return 3;
      4'h6: return t ? 3 : 0;
      4'h8: return (m_cnt != 0) ? 1 : 0;
      4'hA: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t expected(input logic [NCOND-1:0] c, input logic stl);
    logic [1:0] s = 2'b00;
    logic fe = 1, pup = 0, zn = 1, cin = 1, re = 1, ovf = 0, unf = 0;
    int a;
`ifdef USEQ_STACK_CHECK_EN
    ovf = m_ovf; unf = m_unf;
`endif
    if (m_phase == 0) begin zn = 0; cin = 0; end
    else if (m_phase == 1) zn = 0;
    else if (stl) cin = 0;
    else begin
      a   = action(c);
      s   = (a == 1 || a == 2) ? 2'b11 : (a == 3) ? 2'b10 : (a == 4) ? 2'b01 : 2'b00;
      fe  = !(a == 2 || a == 3);
      pup = (a == 2);
      re  = (m_op != 4'h9);
      zn  = (m_op != 4'hB);
    end
    return pack(s, fe, pup, zn, cin, re, m_br, m_br, m_cnt[CW-1:0], m_ill, ovf, unf);
  endfunction

  task automatic advance(input logic [3:0] op, input logic [AW-1:0] br, input logic [2:0] cs,
                         input logic cp, input logic [NCOND-1:0] c, input logic stl);
    int a;
    if (!reset_n) begin model_reset(); return; end
    if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      m_phase = 2; m_op = op; m_br = br; m_csel = cs; m_cpol = cp;
    end else begin
      m_ill = 1'b0;
      if (!stl) begin
        a = action(c);
        if (m_op == 4'h7) m_cnt = int'(m_br);
        if (m_op == 4'h8 && m_cnt > 0) m_cnt = m_cnt - 1;
        if (a == 2) begin if (m_depth == 4) m_ovf = 1'b1; else m_depth = m_depth + 1; end
        if (a == 3) begin if (m_depth == 0) m_unf = 1'b1; else m_depth = m_depth - 1; end
        m_ill = (m_op >= 4'hC);
        m_op = op; m_br = br; m_csel = cs; m_cpol = cp;
      end
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic [AW-1:0] br, input logic [2:0] cs,
                     input logic cp, input logic [NCOND-1:0] c, input logic stl);
    ui_op = op; ui_branch = br; ui_csel = cs; ui_cpol = cp; cond = c; stall = stl;
    exp_q.push_back(expected(c, stl));
    @(posedge clock);
    advance(op, br, cs, cp, c, stl);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
  endtask

  always @(negedge clock) begin
    obs_t e, act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = pack(seq_s, seq_fe_n, seq_pup, seq_zero_n, seq_cin, seq_re_n, seq_d, seq_r,
                 loop_cnt, illegal_op, stk_ovf, stk_unf);
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outs t=%0t got=%h expected=%h (s,fe,pup,zn,cin,re,d,r,cnt,ill,ovf,unf)",
                 $time, act, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(posedge clock); #1;
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);     // RST
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);     // INIT: zero, cin=1
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    cyc(OP_CJMP, 4'hA, 3'd2, 1'b0, 8'h04, 1'b0);
    cyc(OP_CJMP, 4'hA, 3'd2, 1'b1, 8'h04, 1'b0); // first CJMP taken
    cyc(OP_CONT, '0, '0, 1'b0, 8'h04, 1'b0);     // inverted CJMP falls through

    cyc(OP_LDCT, 4'd3, '0, 1'b0, '0, 1'b0);
    repeat (5) cyc(OP_RPCT, 4'h6, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    cyc(OP_LDCT, 4'd7, '0, 1'b0, '0, 1'b0);
    cyc(OP_JSR, 4'h5, '0, 1'b0, '0, 1'b0);
    cyc(OP_RTS, '0, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b1);        // stall while RTS waits
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b1);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    do_reset();
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    repeat (5) cyc(OP_JSR, 4'h9, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    do_reset();
    cyc(OP_RTS, '0, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    cyc(4'hE, 4'h3, '0, 1'b0, '0, 1'b0);
    repeat (3) cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    // Reset landing in the middle of an executing RPCT
    cyc(OP_LDCT, 4'd9, '0, 1'b0, '0, 1'b0);
    cyc(OP_RPCT, 4'h2, '0, 1'b0, '0, 1'b0);
    ui_op = OP_RPCT; cond = '0; stall = 1'b0;
    exp_q.push_back(expected(cond, 1'b0));
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_loop_cnt", 32'(loop_cnt), 32'd0);
    chk("midreset_zero_n", 32'(seq_zero_n), 32'd0);
    chk("midreset_fe_n", 32'(seq_fe_n), 32'd1);
    model_reset();
    @(posedge clock); #1;
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc(4'($urandom_range(0, 15)), AW'($urandom), 3'($urandom), 1'($urandom),
          NCOND'($urandom), ($urandom_range(0, 4) == 0));
    end
    cyc(OP_CONT, '0, '0, 1'b0, '0, 1'b0);

    @(negedge clock); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
